// File: rtl/mux16_sched_pkg.sv
// Shared types and constants for the 16-way round-robin mux scheduler.
package mux16_sched_pkg;

  localparam int N_REQ = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux16_rr_sched_if.sv
// Requester/consumer side of the scheduler: request lines, select, grant and beat handshake.
interface mux16_rr_sched_if;
  import mux16_sched_pkg::*;

  logic [N_REQ-1:0] req;
  logic             ready;
  logic [SEL_W-1:0] sel;
  logic [N_REQ-1:0] gnt;
  logic             valid;
  logic             last;
  logic             busy;

  modport master (
    input  req, ready,
    output sel, gnt, valid, last, busy
  );

  modport slave (
    output req, ready,
    input  sel, gnt, valid, last, busy
  );

endinterface

// File: rtl/mux16_rr_sched_rr_pick16.sv
// Rotating-priority finder: first set req bit searching from ptr+1 upward, wrapping 15->0.
module rr_pick16
  import mux16_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] cand;

  // The pointer itself is visited last, so the previous winner has lowest priority.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = ptr + SEL_W'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler driving the 16:1 mux select for bounded bursts with valid/ready beats.
//   state | meaning
//   IDLE  | no grant; sel holds its last value, waiting for any req
//   XFER  | burst in progress to requester sel; beats counted on valid && ready
module mux16_rr_sched
  import mux16_sched_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  mux16_rr_sched_if.master bus
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic             last_beat;
  logic             accept;
  logic             burst_end;

  rr_pick16 u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign last_beat = (count_q == CNT_W'(BURST_LEN - 1));
  assign accept    = (state_q == XFER) && bus.ready;
  // A dropped request ends the burst even when that edge also accepts a beat.
  assign burst_end = (accept && last_beat) || !bus.req[sel_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = XFER;
          ptr_d   = pick_idx;
          sel_d   = pick_idx;
          gnt_d   = onehot(pick_idx);
          count_d = '0;
        end
      end
      XFER: begin
        if (burst_end) begin
          if (pick_found) begin
            ptr_d   = pick_idx;
            sel_d   = pick_idx;
            gnt_d   = onehot(pick_idx);
            count_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            count_d = '0;
          end
        end else if (accept) begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= SEL_W'(N_REQ - 1);
      sel_q   <= '0;
      gnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      count_q <= count_d;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.gnt   = gnt_q;
  assign bus.valid = (state_q == XFER);
  assign bus.busy  = (state_q == XFER);
  assign bus.last  = (state_q == XFER) && last_beat;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Bench for mux16_rr_sched: two instances (burst 4 and 2) against a behavioural burst model.
module tb_mux16_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        ready;

  int n_cmp = 0;
  int n_bad = 0;
  int acc_a = 0;

  localparam int BL [2] = '{4, 2};

  mux16_rr_sched_if bus_a ();
  mux16_rr_sched_if bus_b ();

  assign bus_a.req   = req;
  assign bus_a.ready = ready;
  assign bus_b.req   = req;
  assign bus_b.ready = ready;

  mux16_rr_sched #(.BURST_LEN(4), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mux16_rr_sched #(.BURST_LEN(2), .CNT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: who holds the grant, how many beats it has had, who won last.
  int  m_busy [2];
  int  m_idx  [2];
  int  m_sel  [2];
  int  m_prev [2];
  int  m_beats[2];
  int  m_w;
  bit  m_known = 1'b0;

  function automatic int rr_next(input int from, input logic [15:0] r);
    for (int k = 1; k <= 16; k++)
      if (r[(from + k) % 16]) return (from + k) % 16;
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] = 0; m_sel[i] = 0; m_prev[i] = 15; m_beats[i] = 0; m_idx[i] = 0;
      end else if (m_busy[i] == 0) begin
        m_w = rr_next(m_prev[i], req);
        if (m_w >= 0) begin
          m_busy[i] = 1; m_idx[i] = m_w; m_sel[i] = m_w; m_prev[i] = m_w; m_beats[i] = 0;
        end
      end else begin
        if (ready) m_beats[i] = m_beats[i] + 1;
        if ((ready && m_beats[i] == BL[i]) || !req[m_idx[i]]) begin
          m_w = rr_next(m_prev[i], req);
          if (m_w >= 0) begin
            m_idx[i] = m_w; m_sel[i] = m_w; m_prev[i] = m_w; m_beats[i] = 0;
          end else begin
            m_busy[i] = 0; m_beats[i] = 0;
          end
        end
      end
    end
    if (rst) m_known = 1'b1;
  end

  task automatic cmp_inst(input int i, input string p, input logic [3:0] s, input logic [15:0] g,
                          input logic v, input logic l, input logic b);
    logic [15:0] eg;
    eg = (m_busy[i] != 0) ? (16'd1 << m_idx[i]) : 16'd0;
    chk({p, ".sel"},   {12'd0, s}, 16'(m_sel[i]));
    chk({p, ".gnt"},   g, eg);
    chk({p, ".valid"}, {15'd0, v}, 16'(m_busy[i] != 0));
    chk({p, ".busy"},  {15'd0, b}, 16'(m_busy[i] != 0));
    chk({p, ".last"},  {15'd0, l}, 16'((m_busy[i] != 0) && (m_beats[i] == BL[i] - 1)));
  endtask

  always @(negedge clk) begin
    if (m_known) begin
      cmp_inst(0, "a", bus_a.sel, bus_a.gnt, bus_a.valid, bus_a.last, bus_a.busy);
      cmp_inst(1, "b", bus_b.sel, bus_b.gnt, bus_b.valid, bus_b.last, bus_b.busy);
    end
  end

  task automatic tick(input logic [15:0] r, input logic rd, input logic rs);
    req = r; ready = rd; rst = rs;
    if (bus_a.valid === 1'b1 && rd && !rs) acc_a++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string nm, input logic [3:0] s, input logic [15:0] g,
                       input logic v, input logic l);
    chk({nm, " sel"},   {12'd0, bus_a.sel}, {12'd0, s});
    chk({nm, " gnt"},   bus_a.gnt, g);
    chk({nm, " valid"}, {15'd0, bus_a.valid}, {15'd0, v});
    chk({nm, " last"},  {15'd0, bus_a.last}, {15'd0, l});
  endtask

  localparam logic [3:0] EXP3 [6] = '{4'd0, 4'd0, 4'd15, 4'd15, 4'd0, 4'd0};
  logic [15:0] r_rand;

  initial begin
    // Reset with all requests asserted, release with none.
    tick(16'hFFFF, 1'b1, 1'b1);
    chk_a("t1 rst0", 4'd0, 16'h0, 1'b0, 1'b0);
    tick(16'hFFFF, 1'b1, 1'b1);
    chk_a("t1 rst1", 4'd0, 16'h0, 1'b0, 1'b0);
    chk("t1 busy", {15'd0, bus_a.busy}, 16'd0);
    tick(16'h0000, 1'b1, 1'b0);
    chk_a("t1 rel0", 4'd0, 16'h0, 1'b0, 1'b0);
    tick(16'h0000, 1'b1, 1'b0);
    chk_a("t1 rel1", 4'd0, 16'h0, 1'b0, 1'b0);

    // Single requester 5, burst of 4, then cleared to idle.
    tick(16'h0020, 1'b1, 1'b0);
    chk_a("t2 grant", 4'd5, 16'h0020, 1'b1, 1'b0);
    tick(16'h0020, 1'b1, 1'b0);
    chk_a("t2 beat2", 4'd5, 16'h0020, 1'b1, 1'b0);
    tick(16'h0020, 1'b1, 1'b0);
    chk_a("t2 beat3", 4'd5, 16'h0020, 1'b1, 1'b0);
    tick(16'h0020, 1'b1, 1'b0);
    chk_a("t2 beat4", 4'd5, 16'h0020, 1'b1, 1'b1);
    tick(16'h0000, 1'b1, 1'b0);
    chk_a("t2 idle", 4'd5, 16'h0000, 1'b0, 1'b0);
    // Same requester held: re-granted back-to-back.
    tick(16'h0020, 1'b1, 1'b0);
    tick(16'h0020, 1'b1, 1'b0);
    tick(16'h0020, 1'b1, 1'b0);
    tick(16'h0020, 1'b1, 1'b0);
    chk_a("t2 last", 4'd5, 16'h0020, 1'b1, 1'b1);
    tick(16'h0020, 1'b1, 1'b0);
    chk_a("t2 b2b", 4'd5, 16'h0020, 1'b1, 1'b0);
    tick(16'h0000, 1'b1, 1'b0);
    chk_a("t2 drop", 4'd5, 16'h0000, 1'b0, 1'b0);

    // Contention 0 vs 15 on the burst-2 instance.
    tick(16'h0000, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick(16'h8001, 1'b1, 1'b0);
      chk($sformatf("t3 sel%0d", k), {12'd0, bus_b.sel}, {12'd0, EXP3[k]});
      chk($sformatf("t3 valid%0d", k), {15'd0, bus_b.valid}, 16'd1);
    end

    // Backpressure on a burst to 7.
    tick(16'h0000, 1'b1, 1'b1);
    tick(16'h0080, 1'b1, 1'b0);
    chk_a("t4 grant", 4'd7, 16'h0080, 1'b1, 1'b0);
    acc_a = 0;
    tick(16'h0080, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick(16'h0080, 1'b0, 1'b0);
      chk_a($sformatf("t4 hold%0d", k), 4'd7, 16'h0080, 1'b1, 1'b0);
    end
    tick(16'h0080, 1'b1, 1'b0);
    chk_a("t4 beat3", 4'd7, 16'h0080, 1'b1, 1'b0);
    tick(16'h0080, 1'b1, 1'b0);
    chk_a("t4 beat4", 4'd7, 16'h0080, 1'b1, 1'b1);
    tick(16'h0000, 1'b1, 1'b0);
    chk_a("t4 done", 4'd7, 16'h0000, 1'b0, 1'b0);
    chk("t4 beats", 16'(acc_a), 16'd4);

    // Abandon at 14, re-arbitration wraps through 15,0,1 to 2.
    tick(16'h0000, 1'b1, 1'b1);
    tick(16'h4000, 1'b1, 1'b0);
    chk_a("t5 grant14", 4'd14, 16'h4000, 1'b1, 1'b0);
    tick(16'h4004, 1'b1, 1'b0);
    chk_a("t5 beat1", 4'd14, 16'h4000, 1'b1, 1'b0);
    tick(16'h0004, 1'b1, 1'b0);
    chk_a("t5 grant2", 4'd2, 16'h0004, 1'b1, 1'b0);

    // Reset mid-burst to 9, then search restarts from index 0.
    tick(16'h0000, 1'b1, 1'b1);
    tick(16'h0200, 1'b1, 1'b0);
    chk_a("t6 grant9", 4'd9, 16'h0200, 1'b1, 1'b0);
    tick(16'h0200, 1'b1, 1'b0);
    tick(16'h0200, 1'b1, 1'b1);
    chk_a("t6 rst", 4'd0, 16'h0000, 1'b0, 1'b0);
    tick(16'h0200, 1'b1, 1'b0);
    chk_a("t6 regrant", 4'd9, 16'h0200, 1'b1, 1'b0);

    // Randomized traffic; the compare process checks every cycle.
    r_rand = 16'h0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0)
        r_rand = ($urandom_range(0, 1) == 0) ? 16'($urandom & $urandom) : 16'($urandom & $urandom & $urandom);
      tick(r_rand, ($urandom_range(0, 3) != 0), ($urandom_range(0, 249) == 0));
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
